// File: rtl/keccak_msg_sched.sv
// Message scheduler for a SHA3-512 core: clears the core, streams a padded-length message
// as 32-bit words, waits for the digest and drains it one word at a time.
module keccak_msg_sched #(
    parameter int MAX_BYTES = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [511:0] msg_in,
    input  logic [6:0]   msg_len,
    output logic         busy,
    output logic         core_reset,
    output logic [31:0]  core_in,
    output logic         core_in_ready,
    output logic         core_is_last,
    output logic [1:0]   core_byte_num,
    input  logic         core_buffer_full,
    input  logic [511:0] core_out,
    input  logic         core_out_ready,
    output logic [31:0]  hash_out32,
    output logic [3:0]   hash_idx,
    output logic         hash_valid,
    input  logic         hash_ready,
    output logic         done
);

    localparam logic [6:0] LP_MAX_LEN = 7'(MAX_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_FEED,
        S_WAIT,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [511:0]   r_msg;
    logic [511:0]   r_digest;
    logic [6:0]     r_len;
    logic [4:0]     r_widx;
    logic [3:0]     r_hidx;

    logic [6:0]     w_len_clamped;
    logic [4:0]     w_nwords;
    logic           w_is_last;
    logic [511:0]   w_msg_shift;
    logic [511:0]   w_dig_shift;
    logic [31:0]    w_word;
    logic           w_feed_take;
    logic           w_drain_take;

    // Keeps the first n bytes of a word (n=0 keeps none: the tail word is empty).
    function automatic logic [31:0] f_tail_mask(input logic [1:0] n);
        case (n)
            2'd1:    f_tail_mask = 32'hFF00_0000;
            2'd2:    f_tail_mask = 32'hFFFF_0000;
            2'd3:    f_tail_mask = 32'hFFFF_FF00;
            default: f_tail_mask = 32'h0000_0000;
        endcase
    endfunction

    assign w_len_clamped = (msg_len > LP_MAX_LEN) ? LP_MAX_LEN : msg_len;
    assign w_nwords      = r_len[6:2];
    assign w_is_last     = (r_widx == w_nwords);
    // Word index 16 (len=64) shifts everything out, giving the all-zero tail word.
    assign w_msg_shift   = r_msg << {r_widx, 5'b0};
    assign w_dig_shift   = r_digest << {r_hidx, 5'b0};
    assign w_word        = w_is_last ? (w_msg_shift[511:480] & f_tail_mask(r_len[1:0]))
                                     : w_msg_shift[511:480];
    assign w_feed_take   = (r_state == S_FEED) && !core_buffer_full;
    assign w_drain_take  = (r_state == S_DRAIN) && hash_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        busy          = (r_state != S_IDLE);
        core_reset    = 1'b0;
        core_in_ready = 1'b0;
        core_in       = 32'h0;
        core_is_last  = 1'b0;
        core_byte_num = 2'd0;
        hash_valid    = 1'b0;
        hash_out32    = 32'h0;
        hash_idx      = r_hidx;
        done          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_CLR;
            end
            S_CLR: begin
                core_reset = 1'b1;
                w_next     = S_FEED;
            end
            S_FEED: begin
                core_in_ready = 1'b1;
                core_in       = w_word;
                core_is_last  = w_is_last;
                core_byte_num = w_is_last ? r_len[1:0] : 2'd0;
                if (w_feed_take && w_is_last) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (core_out_ready) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                hash_valid = 1'b1;
                hash_out32 = w_dig_shift[511:480];
                if (w_drain_take && (r_hidx == 4'd15)) w_next = S_FIN;
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_msg    <= '0;
            r_len    <= '0;
            r_widx   <= '0;
            r_hidx   <= '0;
            r_digest <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_msg <= msg_in;
                        r_len <= w_len_clamped;
                    end
                end
                S_CLR: begin
                    r_widx <= '0;
                    r_hidx <= '0;
                end
                S_FEED: begin
                    if (w_feed_take && !w_is_last) r_widx <= r_widx + 5'd1;
                end
                S_WAIT: begin
                    if (core_out_ready) r_digest <= core_out;
                end
                S_DRAIN: begin
                    if (w_drain_take && (r_hidx != 4'd15)) r_hidx <= r_hidx + 4'd1;
                end
                S_FIN: begin
                    r_hidx <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_msg_sched.sv
// Bench for keccak_msg_sched: table of known messages, abort-by-reset sequence and random jobs,
// all checked against a byte-level model of the word stream and digest drain.
module tb_keccak_msg_sched;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [511:0] msg_in;
    logic [6:0]   msg_len;
    logic         busy;
    logic         core_reset;
    logic [31:0]  core_in;
    logic         core_in_ready;
    logic         core_is_last;
    logic [1:0]   core_byte_num;
    logic         core_buffer_full;
    logic [511:0] core_out;
    logic         core_out_ready;
    logic [31:0]  hash_out32;
    logic [3:0]   hash_idx;
    logic         hash_valid;
    logic         hash_ready;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_word[$];
    bit          exp_last[$];
    logic [1:0]  exp_bn[$];

    typedef struct {
        logic [511:0] msg;
        int           len;
        int           stall;
        int           hold;
        int           nwords;
        logic [31:0]  last_word;
        logic [1:0]   last_bn;
        logic [31:0]  d0;
        logic [31:0]  d15;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    keccak_msg_sched #(.MAX_BYTES(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .msg_in           (msg_in),
        .msg_len          (msg_len),
        .busy             (busy),
        .core_reset       (core_reset),
        .core_in          (core_in),
        .core_in_ready    (core_in_ready),
        .core_is_last     (core_is_last),
        .core_byte_num    (core_byte_num),
        .core_buffer_full (core_buffer_full),
        .core_out         (core_out),
        .core_out_ready   (core_out_ready),
        .hash_out32       (hash_out32),
        .hash_idx         (hash_idx),
        .hash_valid       (hash_valid),
        .hash_ready       (hash_ready),
        .done             (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] left_just(input logic [511:0] v, input int n);
        return v << (8 * (64 - n));
    endfunction

    function automatic logic [511:0] mk_digest(input logic [31:0] d0, input logic [31:0] d15);
        logic [511:0] d;
        d = '0;
        for (int i = 0; i < 16; i++) d[511 - 32*i -: 32] = 32'h5A5A_0000 + 32'(i);
        d[511:480] = d0;
        d[31:0]    = d15;
        return d;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int w = 0; w < 16; w++) v[32*w +: 32] = $urandom;
        return v;
    endfunction

    // Expected word stream from the message bytes: zero past the length, one tail word.
    task automatic build_expected(input logic [511:0] msg, input int len);
        int          eff;
        int          idx;
        logic [31:0] word;
        logic [7:0]  b;
        eff = (len > 64) ? 64 : len;
        exp_word.delete();
        exp_last.delete();
        exp_bn.delete();
        for (int w = 0; w <= eff / 4; w++) begin
            word = 32'h0;
            for (int j = 0; j < 4; j++) begin
                idx  = 4 * w + j;
                b    = (idx < eff) ? msg[511 - 8*idx -: 8] : 8'h00;
                word = {word[23:0], b};
            end
            exp_word.push_back(word);
            exp_last.push_back(w == eff / 4);
            exp_bn.push_back(2'(eff % 4));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"},  32'(busy), 32'd0);
        check({name, "_crst"},  32'(core_reset), 32'd0);
        check({name, "_rdy"},   32'(core_in_ready), 32'd0);
        check({name, "_last"},  32'(core_is_last), 32'd0);
        check({name, "_bnum"},  32'(core_byte_num), 32'd0);
        check({name, "_cin"},   core_in, 32'd0);
        check({name, "_hv"},    32'(hash_valid), 32'd0);
        check({name, "_hout"},  hash_out32, 32'd0);
        check({name, "_hidx"},  32'(hash_idx), 32'd0);
        check({name, "_done"},  32'(done), 32'd0);
    endtask

    task automatic apply_reset();
        reset            = 1'b0;
        start            = 1'b0;
        core_buffer_full = 1'b0;
        core_out_ready   = 1'b0;
        hash_ready       = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // stall: 0 none, 1 three-cycle hold at word 3, 2 random; hold: 0 none, 1 two-cycle at idx 7, 2 random.
    task automatic run_job(input logic [511:0] msg, input int len, input logic [511:0] digest,
                           input int stall, input int hold, input int abort_at,
                           output int nfed, output logic [31:0] lastw, output logic [1:0] lastbn,
                           output logic [31:0] h0, output logic [31:0] h15);
        int k, j, cyc, stalled, held;
        bit full, rdy, finished;
        nfed = 0; lastw = 32'hFFFF_FFFF; lastbn = 2'd0; h0 = 32'h0; h15 = 32'h0;
        build_expected(msg, len);
        @(negedge clk);
        start   = 1'b1;
        msg_in  = msg;
        msg_len = 7'(len);
        @(negedge clk);
        start  = 1'b0;
        msg_in = rand512();
        check("clr_busy", 32'(busy), 32'd1);
        check("clr_crst", 32'(core_reset), 32'd1);
        check("clr_rdy",  32'(core_in_ready), 32'd0);
        k = 0; cyc = 0; stalled = 0; finished = 0;
        while (!finished) begin
            @(negedge clk);
            if (cyc++ > 1000 || k >= exp_word.size()) begin
                check("feed_bound", 32'd1, 32'd0);
                apply_reset();
                return;
            end
            check("feed_rdy",  32'(core_in_ready), 32'd1);
            check("feed_crst", 32'(core_reset), 32'd0);
            check("feed_word", core_in, exp_word[k]);
            check("feed_last", 32'(core_is_last), 32'(exp_last[k]));
            if (exp_last[k]) check("feed_bnum", 32'(core_byte_num), 32'(exp_bn[k]));
            if (abort_at == k) begin
                reset = 1'b0;
                #1;
                check_reset_outputs("abort");
                @(negedge clk);
                check_reset_outputs("abort_hold");
                start = 1'b0;
                core_buffer_full = 1'b0;
                reset = 1'b1;
                return;
            end
            case (stall)
                1:       full = (k == 3) && (stalled < 3);
                2:       full = ($urandom % 3 == 0);
                default: full = 1'b0;
            endcase
            if (full) stalled++;
            core_buffer_full = full;
            start = 1'($urandom % 2);
            if (!full) begin
                nfed++;
                if (exp_last[k]) begin
                    lastw    = core_in;
                    lastbn   = core_byte_num;
                    finished = 1;
                end
                k++;
            end
        end
        @(negedge clk);
        core_buffer_full = 1'b0;
        check("wait_rdy",  32'(core_in_ready), 32'd0);
        check("wait_cin",  core_in, 32'd0);
        check("wait_busy", 32'(busy), 32'd1);
        repeat (2) begin
            @(negedge clk);
            check("wait_hv", 32'(hash_valid), 32'd0);
        end
        core_out       = digest;
        core_out_ready = 1'b1;
        j = 0; cyc = 0; held = 0;
        while (j < 16) begin
            @(negedge clk);
            core_out_ready = 1'b0;
            core_out       = rand512();
            if (cyc++ > 1000) begin
                check("drain_bound", 32'd1, 32'd0);
                apply_reset();
                return;
            end
            check("drain_hv",   32'(hash_valid), 32'd1);
            check("drain_idx",  32'(hash_idx), 32'(j));
            check("drain_word", hash_out32, digest[511 - 32*j -: 32]);
            check("drain_done", 32'(done), 32'd0);
            if (j == 0)  h0  = hash_out32;
            if (j == 15) h15 = hash_out32;
            case (hold)
                1:       rdy = !((j == 7) && (held < 2));
                2:       rdy = ($urandom % 3 != 0);
                default: rdy = 1'b1;
            endcase
            if (!rdy) held++;
            hash_ready = rdy;
            start = 1'($urandom % 2);
            if (rdy) j++;
        end
        @(negedge clk);
        start      = 1'b0;
        hash_ready = 1'b0;
        check("fin_done", 32'(done), 32'd1);
        check("fin_hv",   32'(hash_valid), 32'd0);
        @(negedge clk);
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [511:0] fox;
        logic [511:0] m, dig;
        int           nfed, len;
        logic [31:0]  lastw, h0, h15;
        logic [1:0]   lastbn;

        fox = "The quick brown fox jumps over the lazy dog";
        fox = left_just(fox, 43);
        m = fox;
        m[511 - 8*43 -: 8] = 8'h2E;

        vecs[0] = '{fox, 43, 0, 0, 11, 32'h646F_6700, 2'd3, 32'hD135_BB84, 32'h9659_F609};
        vecs[1] = '{m,   44, 1, 1, 12, 32'h0000_0000, 2'd0, 32'hAB71_92D2, 32'hEB52_D760};
        vecs[2] = '{'0,  0,  0, 0, 1,  32'h0000_0000, 2'd0, 32'h0EAB_42DE, 32'h3670_680E};
        vecs[3] = '{{40'hA1A2A3A4A5, 472'h0}, 5, 1, 1, 2, 32'hA500_0000, 2'd1,
                    32'h12F4_A85B, 32'h0DF6_DDFB};
        vecs[4] = '{{16{32'hDEAD_BEEF}}, 64, 0, 0, 17, 32'h0000_0000, 2'd0,
                    32'h1111_1111, 32'h2222_2222};
        vecs[5] = '{{16{32'hDEAD_BEEF}}, 63, 0, 0, 16, 32'hDEAD_BE00, 2'd3,
                    32'h3333_3333, 32'h4444_4444};
        vecs[6] = '{{16{32'hCAFE_F00D}}, 100, 2, 2, 17, 32'h0000_0000, 2'd0,
                    32'h5555_5555, 32'h6666_6666};
        vecs[7] = '{{8'h7F, 504'h0}, 1, 0, 0, 1, 32'h7F00_0000, 2'd1,
                    32'h7777_7777, 32'h8888_8888};

        reset = 1'b0; start = 1'b0; msg_in = '0; msg_len = '0;
        core_buffer_full = 1'b0; core_out = '0; core_out_ready = 1'b0; hash_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            dig = mk_digest(vecs[i].d0, vecs[i].d15);
            run_job(vecs[i].msg, vecs[i].len, dig, vecs[i].stall, vecs[i].hold, -1,
                    nfed, lastw, lastbn, h0, h15);
            check($sformatf("v%0d_nwords", i), 32'(nfed), 32'(vecs[i].nwords));
            check($sformatf("v%0d_lastw", i),  lastw, vecs[i].last_word);
            check($sformatf("v%0d_lastbn", i), 32'(lastbn), 32'(vecs[i].last_bn));
            check($sformatf("v%0d_h0", i),     h0, vecs[i].d0);
            check($sformatf("v%0d_h15", i),    h15, vecs[i].d15);
        end

        dig = mk_digest(32'hD135_BB84, 32'h9659_F609);
        run_job(fox, 43, dig, 0, 0, 5, nfed, lastw, lastbn, h0, h15);
        run_job(fox, 43, dig, 0, 0, -1, nfed, lastw, lastbn, h0, h15);
        check("rerun_nwords", 32'(nfed), 32'd11);
        check("rerun_lastw",  lastw, 32'h646F_6700);
        check("rerun_h0",     h0, 32'hD135_BB84);
        check("rerun_h15",    h15, 32'h9659_F609);

        for (int r = 0; r < 25; r++) begin
            len = $urandom_range(0, 80);
            run_job(rand512(), len, rand512(), 2, 2, -1, nfed, lastw, lastbn, h0, h15);
            check("rand_nwords", 32'(nfed), 32'(((len > 64) ? 64 : len) / 4 + 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
